knap_seq_eval: RTL and testbench

KNAP_SEQ_EVAL -- requirements
Module: knap_seq_eval

---
 rtl/knap_pkg.sv | 8 +
 rtl/knap_item_table.sv | 39 +++
 rtl/knap_seq_eval.sv | 120 ++++++++++++
 tb/tb_knap_seq_eval.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/knap_pkg.sv
// knap_pkg: shared defaults and state type for the knapsack selection evaluator
package knap_pkg;
  localparam int N_ITEMS = 26;
  localparam int IW = 8;
  localparam int AW = 13;
  localparam int IDXW = 5;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/knap_item_table.sv
// knap_item_table: per-item value/weight/volume storage, one write port, one async read port
module knap_item_table
  import knap_pkg::*;
#(
  parameter int N_ITEMS = knap_pkg::N_ITEMS,
  parameter int IW = knap_pkg::IW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [IDXW-1:0] wr_addr,
  input  logic [IW-1:0]   wr_value,
  input  logic [IW-1:0]   wr_weight,
  input  logic [IW-1:0]   wr_volume,
  input  logic [IDXW-1:0] rd_addr,
  output logic [IW-1:0]   rd_value,
  output logic [IW-1:0]   rd_weight,
  output logic [IW-1:0]   rd_volume
);
  logic [IW-1:0] val_mem [N_ITEMS];
  logic [IW-1:0] wgt_mem [N_ITEMS];
  logic [IW-1:0] vol_mem [N_ITEMS];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        val_mem[i] <= '0;
        wgt_mem[i] <= '0;
        vol_mem[i] <= '0;
      end
    end else if (we) begin
      val_mem[wr_addr] <= wr_value;
      wgt_mem[wr_addr] <= wr_weight;
      vol_mem[wr_addr] <= wr_volume;
    end
  end
  assign rd_value  = val_mem[rd_addr];
  assign rd_weight = wgt_mem[rd_addr];
  assign rd_volume = vol_mem[rd_addr];
endmodule

// File: rtl/knap_seq_eval.sv
// knap_seq_eval: sequential one-item-per-cycle knapsack feasibility check with best-so-far record
module knap_seq_eval
  import knap_pkg::*;
#(
  parameter int N_ITEMS = knap_pkg::N_ITEMS,
  parameter int IW = knap_pkg::IW,
  parameter int AW = knap_pkg::AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [4:0]         cfg_addr,
  input  logic [IW-1:0]      cfg_value,
  input  logic [IW-1:0]      cfg_weight,
  input  logic [IW-1:0]      cfg_volume,
  input  logic [AW-1:0]      min_value,
  input  logic [AW-1:0]      max_weight,
  input  logic [AW-1:0]      max_volume,
  input  logic               in_valid,
  input  logic [N_ITEMS-1:0] in_sel,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_ok,
  output logic [AW-1:0]      out_value,
  output logic [AW-1:0]      out_weight,
  output logic [AW-1:0]      out_volume,
  input  logic               best_clr,
  output logic               best_valid,
  output logic [AW-1:0]      best_value,
  output logic [N_ITEMS-1:0] best_sel,
  output logic               busy
);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_ITEMS - 1);
  state_t state, state_d;
  logic [IDXW-1:0] idx;
  logic [N_ITEMS-1:0] sel_q;
  logic [AW-1:0] min_q, maxw_q, maxv_q;
  logic [AW-1:0] acc_v, acc_w, acc_c;
  logic [IW-1:0] rd_value, rd_weight, rd_volume;
  logic tbl_we, accept, retire, improve;
  assign busy      = state != IDLE;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_ready && in_valid;
  assign retire    = out_valid && out_ready;
  assign tbl_we    = cfg_we && !busy && (32'(cfg_addr) < N_ITEMS);
  assign out_value  = acc_v;
  assign out_weight = acc_w;
  assign out_volume = acc_c;
  assign out_ok  = out_valid && (acc_v >= min_q) && (acc_w <= maxw_q) && (acc_c <= maxv_q);
  assign improve = out_ok && (!best_valid || acc_v > best_value);
  knap_item_table #(.N_ITEMS(N_ITEMS), .IW(IW)) u_table (
    .clk(clk),
    .rst(rst),
    .we(tbl_we),
    .wr_addr(cfg_addr),
    .wr_value(cfg_value),
    .wr_weight(cfg_weight),
    .wr_volume(cfg_volume),
    .rd_addr(idx),
    .rd_value(rd_value),
    .rd_weight(rd_weight),
    .rd_volume(rd_volume)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    state_d = accept ? ACCUM :
              (state == ACCUM && idx == IDX_LAST) ? DONE :
              retire ? IDLE : state;
  end
  // Every index is visited so latency is fixed regardless of the selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      sel_q  <= '0;
      min_q  <= '0;
      maxw_q <= '0;
      maxv_q <= '0;
      acc_v  <= '0;
      acc_w  <= '0;
      acc_c  <= '0;
    end else if (accept) begin
      idx    <= '0;
      sel_q  <= in_sel;
      min_q  <= min_value;
      maxw_q <= max_weight;
      maxv_q <= max_volume;
      acc_v  <= '0;
      acc_w  <= '0;
      acc_c  <= '0;
    end else if (state == ACCUM) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (sel_q[idx]) begin
        acc_v <= acc_v + AW'(rd_value);
        acc_w <= acc_w + AW'(rd_weight);
        acc_c <= acc_c + AW'(rd_volume);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_valid <= 1'b0;
      best_value <= '0;
      best_sel   <= '0;
    end else if (best_clr) begin
      best_valid <= 1'b0;
      best_value <= '0;
      best_sel   <= '0;
    end else if (retire && improve) begin
      best_valid <= 1'b1;
      best_value <= acc_v;
      best_sel   <= sel_q;
    end
  end
endmodule

// File: tb/tb_knap_seq_eval.sv
// tb_knap_seq_eval: directed self-checking bench for knap_seq_eval
module tb_knap_seq_eval;
  localparam int N = 26;
  localparam int AW = 13;
  localparam logic [N-1:0] SEL_A = 26'h2040400;
  localparam logic [N-1:0] SEL_B = 26'h2000420;
  logic clk = 0, rst = 1;
  logic cfg_we = 0;
  logic [4:0] cfg_addr = 0;
  logic [7:0] cfg_value = 0, cfg_weight = 0, cfg_volume = 0;
  logic [AW-1:0] min_value = 0, max_weight = 0, max_volume = 0;
  logic in_valid = 0;
  logic [N-1:0] in_sel = 0;
  logic in_ready, out_valid, out_ok, best_valid, busy;
  logic out_ready = 0, best_clr = 0;
  logic [AW-1:0] out_value, out_weight, out_volume, best_value;
  logic [N-1:0] best_sel;
  int checks = 0, errors = 0;

  knap_seq_eval dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_value(cfg_value), .cfg_weight(cfg_weight), .cfg_volume(cfg_volume),
    .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
    .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ok(out_ok),
    .out_value(out_value), .out_weight(out_weight), .out_volume(out_volume),
    .best_clr(best_clr), .best_valid(best_valid), .best_value(best_value),
    .best_sel(best_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [7:0] v, w, c);
    cfg_addr = a; cfg_value = v; cfg_weight = w; cfg_volume = c; cfg_we = 1;
    @(posedge clk); #1 cfg_we = 0;
  endtask

  task automatic start(input logic [N-1:0] s, input logic [AW-1:0] mv, mw, mc);
    in_sel = s; min_value = mv; max_weight = mw; max_volume = mc; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic pop(input logic clr);
    out_ready = 1; best_clr = clr;
    @(posedge clk); #1 out_ready = 0; best_clr = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || out_ok !== 0 || busy !== 0) begin
      errors++; $display("FAIL reset_ctrl got rdy=%b ov=%b ok=%b busy=%b want 1 0 0 0", in_ready, out_valid, out_ok, busy);
    end
    checks++;
    if (best_valid !== 0 || best_value !== 0 || best_sel !== 0 || out_value !== 0) begin
      errors++; $display("FAIL reset_best got bv=%b val=%0d sel=%h oval=%0d want 0", best_valid, best_value, best_sel, out_value);
    end
    rst = 0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1) begin errors++; $display("FAIL reset_release in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    wr(0, 4, 28, 27); wr(10, 30, 5, 5); wr(18, 29, 1, 28); wr(25, 30, 13, 22); wr(5, 29, 1, 1);
    start(SEL_A, 80, 100, 100);
    repeat (N - 1) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || busy !== 1) begin errors++; $display("FAIL basic_early got ov=%b busy=%b want 0 1", out_valid, busy); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1) begin errors++; $display("FAIL basic_latency out_valid got %b want 1", out_valid); end
    checks++;
    if (out_value !== 89 || out_weight !== 19 || out_volume !== 55 || out_ok !== 1) begin
      errors++; $display("FAIL basic_totals got %0d/%0d/%0d ok=%b want 89/19/55 ok=1", out_value, out_weight, out_volume, out_ok);
    end
    pop(0);
    checks++;
    if (best_valid !== 1 || best_value !== 89 || best_sel !== SEL_A || in_ready !== 1) begin
      errors++; $display("FAIL basic_best got bv=%b val=%0d sel=%h rdy=%b want 1 89 %h 1", best_valid, best_value, best_sel, in_ready, SEL_A);
    end
  endtask

  task automatic test_min90;
    start(SEL_A, 90, 100, 100);
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1 || out_value !== 89 || out_ok !== 0) begin
      errors++; $display("FAIL min90_verdict got ov=%b val=%0d ok=%b want 1 89 0", out_valid, out_value, out_ok);
    end
    pop(0);
    checks++;
    if (best_valid !== 1 || best_value !== 89 || best_sel !== SEL_A) begin
      errors++; $display("FAIL min90_best got bv=%b val=%0d sel=%h want 1 89 %h", best_valid, best_value, best_sel, SEL_A);
    end
  endtask

  task automatic test_stall_tie;
    logic stable;
    start(SEL_B, 80, 100, 100);
    cfg_addr = 1; cfg_value = 200; cfg_weight = 0; cfg_volume = 0; cfg_we = 1;
    min_value = 200; max_weight = 0; max_volume = 0;
    @(posedge clk); #1 cfg_we = 0;
    repeat (N - 1) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1 || out_value !== 89 || out_weight !== 19 || out_volume !== 28 || out_ok !== 1) begin
      errors++; $display("FAIL stall_totals got ov=%b %0d/%0d/%0d ok=%b want 1 89/19/28 ok=1", out_valid, out_value, out_weight, out_volume, out_ok);
    end
    stable = 1;
    in_valid = 1; in_sel = SEL_A;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1 || in_ready !== 0 || out_value !== 89 || out_weight !== 19 || out_volume !== 28 || out_ok !== 1) stable = 0;
    end
    in_valid = 0;
    checks++;
    if (stable !== 1) begin errors++; $display("FAIL stall_hold got unstable outputs val=%0d rdy=%b want stable 89 rdy=0", out_value, in_ready); end
    pop(0);
    checks++;
    if (busy !== 0 || best_sel !== SEL_A || best_value !== 89) begin
      errors++; $display("FAIL tie_keep got busy=%b sel=%h val=%0d want 0 %h 89", busy, best_sel, best_value, SEL_A);
    end
    start(26'h2, 0, 100, 100);
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if (out_value !== 0 || out_weight !== 0 || out_ok !== 1) begin
      errors++; $display("FAIL cfg_busy_ignored got val=%0d w=%0d ok=%b want 0 0 1", out_value, out_weight, out_ok);
    end
    pop(0);
  endtask

  task automatic test_same_edge;
    cfg_addr = 2; cfg_value = 7; cfg_weight = 3; cfg_volume = 2; cfg_we = 1;
    in_sel = 26'h4; min_value = 0; max_weight = 100; max_volume = 100; in_valid = 1;
    @(posedge clk); #1 cfg_we = 0; in_valid = 0;
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if (out_value !== 7 || out_weight !== 3 || out_volume !== 2 || out_ok !== 1) begin
      errors++; $display("FAIL same_edge got %0d/%0d/%0d ok=%b want 7/3/2 ok=1", out_value, out_weight, out_volume, out_ok);
    end
    pop(0);
    checks++;
    if (best_value !== 89) begin errors++; $display("FAIL same_edge_best got %0d want 89", best_value); end
  endtask

  task automatic test_empty;
    start(0, 0, 0, 0);
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if (out_value !== 0 || out_weight !== 0 || out_volume !== 0 || out_ok !== 1) begin
      errors++; $display("FAIL empty_min0 got %0d/%0d/%0d ok=%b want 0/0/0 ok=1", out_value, out_weight, out_volume, out_ok);
    end
    pop(0);
    start(0, 1, 0, 0);
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1 || out_ok !== 0) begin errors++; $display("FAIL empty_min1 got ov=%b ok=%b want 1 0", out_valid, out_ok); end
    pop(0);
  endtask

  task automatic test_best_clr;
    best_clr = 1;
    @(posedge clk); #1 best_clr = 0;
    checks++;
    if (best_valid !== 0 || best_value !== 0 || best_sel !== 0) begin
      errors++; $display("FAIL best_clr got bv=%b val=%0d sel=%h want 0 0 0", best_valid, best_value, best_sel);
    end
    start(26'h4, 0, 100, 100);
    repeat (N) @(posedge clk);
    #1 pop(1);
    checks++;
    if (best_valid !== 0 || best_value !== 0) begin
      errors++; $display("FAIL clr_wins got bv=%b val=%0d want 0 0", best_valid, best_value);
    end
    start(26'h4, 0, 100, 100);
    repeat (N) @(posedge clk);
    #1 pop(0);
    checks++;
    if (best_valid !== 1 || best_value !== 7 || best_sel !== 26'h4) begin
      errors++; $display("FAIL best_from_empty got bv=%b val=%0d sel=%h want 1 7 4", best_valid, best_value, best_sel);
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < N; i++) wr(5'(i), 255, 255, 255);
    start({N{1'b1}}, 0, 100, 8000);
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if (out_value !== 6630 || out_weight !== 6630 || out_volume !== 6630 || out_ok !== 0) begin
      errors++; $display("FAIL full_sum got %0d/%0d/%0d ok=%b want 6630/6630/6630 ok=0", out_value, out_weight, out_volume, out_ok);
    end
    pop(0);
    checks++;
    if (best_value !== 7 || best_sel !== 26'h4) begin errors++; $display("FAIL full_best got val=%0d sel=%h want 7 4", best_value, best_sel); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    start(26'h1, 0, 8000, 8000);
    repeat (12) @(posedge clk);
    #1 rst = 1;
    #1;
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0) begin
      errors++; $display("FAIL rst_mid_async got rdy=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
    @(posedge clk); #1 rst = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 0 || in_ready !== 1) seen = 1;
    end
    checks++;
    if (seen !== 0 || best_valid !== 0) begin
      errors++; $display("FAIL rst_mid_discard got ov_seen=%b bv=%b want 0 0", seen, best_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min90();
    test_stall_tie();
    test_same_edge();
    test_empty();
    test_best_clr();
    test_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
